// File: rtl/fft_out_frame_buffer.sv
// Ping-pong frame buffer behind the 64-point FFT core's serial output.
// The core cannot be stalled. Each 64-word output frame is therefore collected
// into one of two banks and then replayed on a valid/ready stream. Each word
// carries its bin index, a last flag and a frame sequence number. A frame that
// arrives while both banks hold undelivered data is dropped whole and counted.
module fft_out_frame_buffer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 64,
    parameter int IDX_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [IDX_W-1:0]  m_index,
    output logic              m_last,
    output logic [7:0]        m_frame,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    typedef enum logic {W_FILL, W_DROP}   wstate_e;
    typedef enum logic {R_IDLE, R_STREAM} rstate_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wstate_e           wstate_q, wstate_d;
    rstate_e           rstate_q, rstate_d;
    logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [7:0]        seq_q, seq_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic [IDX_W-1:0]  m_index_q, m_index_d;
    logic [7:0]        m_frame_q, m_frame_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0] mem_q [2*FRAME_LEN];

    // ------------------------------------------------------------------
    // Control signals shared between the two FSMs
    // ------------------------------------------------------------------
    logic             handshake;
    logic             release_bank;   // read side frees rd_bank this edge
    logic             bank_avail;     // wr_bank may be claimed this edge
    logic             mem_we;
    logic             set_full;
    logic             drop_evt;
    logic             clr_full;
    logic             load;
    logic [IDX_W:0]   rd_addr;

    assign handshake    = m_valid_q & m_ready;
    assign release_bank = (rstate_q == R_STREAM) & handshake & (m_index_q == LAST_IDX);
    // The bank being released this edge is free for a new word 0 (bypass).
    assign bank_avail   = ~full_q[wr_bank_q] | (release_bank & (rd_bank_q == wr_bank_q));

    // ------------------------------------------------------------------
    // State registers for both FSMs and the datapath
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q   <= W_FILL;
            rstate_q   <= R_IDLE;
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            seq_q      <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_index_q  <= '0;
            m_frame_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            seq_q      <= seq_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_index_q  <= m_index_d;
            m_frame_q  <= m_frame_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Frame storage write port
    // NOTE: the storage array has no reset; the full flags alone decide
    // whether a bank's contents are meaningful, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------
    // Choose fill or drop for the incoming frame; the choice is made only at word 0.
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_FILL: begin
                if (in_valid && (wr_cnt_q == ZERO_IDX) && !bank_avail) begin
                    wstate_d = W_DROP;
                end
            end
            W_DROP: begin
                if (in_valid && (wr_cnt_q == LAST_IDX)) begin
                    wstate_d = W_FILL;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write FSM: outputs (memory write, word counter, bank flip, drop event)
    // ------------------------------------------------------------------
    // Store or discard each valid word and mark a bank full on its last word.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        mem_we    = 1'b0;
        set_full  = 1'b0;
        drop_evt  = 1'b0;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (in_valid) begin
            case (wstate_q)
                W_FILL: begin
                    if ((wr_cnt_q != ZERO_IDX) || bank_avail) begin
                        mem_we = 1'b1;
                        if (wr_cnt_q == LAST_IDX) begin
                            set_full  = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                            wr_cnt_d  = '0;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end else begin
                        // Word 0 of a frame with nowhere to go: discard it and
                        // keep counting so the whole frame is skipped.
                        drop_evt = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
                W_DROP: begin
                    wr_cnt_d = (wr_cnt_q == LAST_IDX) ? ZERO_IDX : wr_cnt_q + 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: next state
    // ------------------------------------------------------------------
    // Start streaming when the current read bank fills. Return to idle only when
    // a frame ends and the other bank is not ready.
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rstate_d = R_STREAM;
                end
            end
            R_STREAM: begin
                if (release_bank && !full_q[~rd_bank_q]) begin
                    rstate_d = R_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM: outputs (output register loads, bank release, sequence)
    // ------------------------------------------------------------------
    // Load the output register and advance the index. On the last word, release
    // the bank and continue straight into the next frame if it is present.
    always_comb begin
        load      = 1'b0;
        clr_full  = 1'b0;
        rd_addr   = {rd_bank_q, ZERO_IDX};
        rd_bank_d = rd_bank_q;
        seq_d     = seq_q;
        m_valid_d = m_valid_q;
        m_index_d = m_index_q;
        m_frame_d = m_frame_q;
        case (rstate_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load      = 1'b1;
                    rd_addr   = {rd_bank_q, ZERO_IDX};
                    m_valid_d = 1'b1;
                    m_index_d = '0;
                    m_frame_d = seq_q;
                end
            end
            R_STREAM: begin
                if (handshake) begin
                    if (m_index_q != LAST_IDX) begin
                        load      = 1'b1;
                        rd_addr   = {rd_bank_q, m_index_q + 1'b1};
                        m_index_d = m_index_q + 1'b1;
                    end else begin
                        clr_full  = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        seq_d     = seq_q + 8'd1;
                        if (full_q[~rd_bank_q]) begin
                            load      = 1'b1;
                            rd_addr   = {~rd_bank_q, ZERO_IDX};
                            m_index_d = '0;
                            m_frame_d = seq_q + 8'd1;
                        end else begin
                            m_valid_d = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    // Output word register, fed from whichever bank address the read FSM selected.
    always_comb begin
        m_data_d = load ? mem_q[rd_addr] : m_data_q;
    end

    // Bank occupancy. A bank cannot be completed and released in the same
    // cycle, so the clear and the set never collide on one flag.
    always_comb begin
        full_d = full_q;
        if (clr_full) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Drop reporting: one-cycle pulse plus saturating count.
    always_comb begin
        overflow_d = drop_evt;
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_index  = m_index_q;
    assign m_last   = (m_index_q == LAST_IDX) & m_valid_q;
    assign m_frame  = m_frame_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fft_out_frame_buffer.sv
// Self-checking bench for fft_out_frame_buffer.
// Each scenario row drives one run of frames. A queue built from the row's drop
// mask predicts every word the sink should receive, and a negedge monitor
// checks each handshake and the hold of stalled outputs.
module tb_fft_out_frame_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [5:0]  m_index;
    logic        m_last;
    logic [7:0]  m_frame;
    logic        overflow;
    logic [7:0]  drop_cnt;

    fft_out_frame_buffer #(.DATA_W(32), .FRAME_LEN(64), .IDX_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_index  (m_index),
        .m_last   (m_last),
        .m_frame  (m_frame),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n_frames;
        int         rdy;        // 0: always ready, 1: held low while frames arrive, 2: random
        bit         gaps;       // random in_valid gaps
        logic [7:0] drop_mask;  // frames expected to be dropped
        int         exp_drop;
        int         exp_ovf;
        int         exp_span;   // cycles first..last handshake, -1 = not checked
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
        logic [7:0]  frame;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   mon_en = 1'b1;
    exp_t exp_q[$];
    exp_t e_mon;
    int   hs_cnt = 0;
    int   first_cyc = -1;
    int   last_cyc = 0;
    int   ovf_cnt = 0;
    bit   prev_stall = 1'b0;
    logic [46:0] prev_vec = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_of(input int r, input int k, input int i);
        return (32'(r) << 24) | (32'(k) << 8) | 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Sink ready generator
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_stable", {m_valid, m_data, m_index, m_frame}, prev_vec);
            end
            if (m_valid && m_ready && mon_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h idx %0d, expected none", m_data, m_index);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("out_data", m_data, e_mon.data);
                    check("out_index", m_index, e_mon.idx);
                    check("out_last", m_last, e_mon.idx == 6'd63);
                    check("out_frame", m_frame, e_mon.frame);
                end
                hs_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (overflow) ovf_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_vec   = {m_valid, m_data, m_index, m_frame};
        end
    end

    task automatic clear_tracking();
        exp_q.delete();
        hs_cnt    = 0;
        first_cyc = -1;
        last_cyc  = 0;
        ovf_cnt   = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) tick();
        rst = 1'b0;
        clear_tracking();
    endtask

    task automatic push_frame(input int r, input int k, input int fseq);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            e.data  = data_of(r, k, i);
            e.idx   = 6'(i);
            e.frame = 8'(fseq);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int r, input int k, input bit gaps);
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin
                while ($urandom_range(3) != 0) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = data_of(r, k, i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int fseq;
        int n;

        vecs[0] = '{n_frames: 1,  rdy: 0, gaps: 1'b0, drop_mask: 8'h00, exp_drop: 0, exp_ovf: 0, exp_span: 63};
        vecs[1] = '{n_frames: 2,  rdy: 0, gaps: 1'b0, drop_mask: 8'h00, exp_drop: 0, exp_ovf: 0, exp_span: 127};
        vecs[2] = '{n_frames: 3,  rdy: 0, gaps: 1'b0, drop_mask: 8'h00, exp_drop: 0, exp_ovf: 0, exp_span: 191};
        vecs[3] = '{n_frames: 3,  rdy: 1, gaps: 1'b0, drop_mask: 8'h04, exp_drop: 1, exp_ovf: 1, exp_span: -1};
        vecs[4] = '{n_frames: 10, rdy: 2, gaps: 1'b1, drop_mask: 8'h00, exp_drop: 0, exp_ovf: 0, exp_span: -1};

        for (int r = 0; r < 5; r++) begin
            rdy_mode = vecs[r].rdy;
            do_reset();
            check("rst_state", {m_valid, m_index, m_last, m_frame, overflow, drop_cnt, m_data}, '0);
            fseq = 0;
            for (int k = 0; k < vecs[r].n_frames; k++) begin
                if (!vecs[r].drop_mask[k]) begin
                    push_frame(r, k, fseq);
                    fseq++;
                end
            end
            for (int k = 0; k < vecs[r].n_frames; k++) begin
                send_frame(r, k, vecs[r].gaps);
            end
            if (r == 0) begin
                check("lat_after_last_word", m_valid, 1'b0);
                tick();
                check("lat_valid_rises", m_valid, 1'b1);
            end
            if (vecs[r].rdy == 1) begin
                repeat (5) tick();
                check("stalled_valid", m_valid, 1'b1);
                check("stalled_index", m_index, 6'd0);
                rdy_mode = 0;
            end
            wait_drain(6000);
            repeat (10) tick();
            check("delivered", hs_cnt, 64 * fseq);
            check("drop_cnt", drop_cnt, vecs[r].exp_drop);
            check("ovf_pulses", ovf_cnt, vecs[r].exp_ovf);
            if (vecs[r].exp_span >= 0) begin
                check("contig_span", last_cyc - first_cyc, vecs[r].exp_span);
            end
        end

        // Reset in the middle of streaming with the second bank also full.
        rdy_mode = 1;
        do_reset();
        mon_en = 1'b0;
        send_frame(5, 0, 1'b0);
        send_frame(5, 1, 1'b0);
        repeat (3) tick();
        rdy_mode = 0;
        n = 0;
        while (!(m_valid && m_index == 6'd20) && n < 1000) begin
            tick();
            n++;
        end
        check("reach_idx20", {m_valid, m_index}, {1'b1, 6'd20});
        rst = 1'b1;
        tick();
        check("rst_mid_out", {m_valid, drop_cnt, m_frame, m_index}, '0);
        rst = 1'b0;
        clear_tracking();
        mon_en = 1'b1;
        push_frame(6, 0, 0);
        send_frame(6, 0, 1'b0);
        wait_drain(2000);
        repeat (10) tick();
        check("post_rst_delivered", hs_cnt, 64);

        // Sustained overflow: two frames held, 300 dropped.
        rdy_mode = 1;
        do_reset();
        push_frame(7, 0, 0);
        push_frame(7, 1, 1);
        for (int k = 0; k < 302; k++) begin
            send_frame(7, k, 1'b0);
        end
        repeat (3) tick();
        check("drop_saturated", drop_cnt, 8'd255);
        check("ovf_every_drop", ovf_cnt, 300);
        rdy_mode = 0;
        wait_drain(2000);
        repeat (10) tick();
        check("sat_delivered", hs_cnt, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/fft_out_frame_buffer.md
Name: fft_out_frame_buffer

Overview:
- Downstream consumer of the 64-point FFT core's serial output (Out_Stream / Data_Out).
- Collects each 64-word output frame into a two-bank ping-pong buffer.
- Replays each frame on a valid/ready stream with index, last flag and frame sequence number, so a stalling sink cannot corrupt frames.
- Frames arriving while both banks are occupied are dropped whole and counted; the core itself has no backpressure.

Parameters:
- DATA_W, 32, word width (16-bit real and 16-bit imaginary, same packing as Out_Stream).
- FRAME_LEN, 64, words per frame.
- IDX_W, 6, width of the index counter; log2(FRAME_LEN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  FFT output word; connects to Out_Stream.
- in_valid  input  1  word valid; connects to Data_Out.
- m_data  output  DATA_W  buffered word.
- m_valid  output  1  m_data valid.
- m_ready  input  1  sink accepts the word when m_valid & m_ready.
- m_index  output  IDX_W  bin index of m_data within its frame.
- m_last  output  1  high with index FRAME_LEN-1.
- m_frame  output  8  sequence number of the frame on m_data; wraps 255->0.
- overflow  output  1  one-cycle pulse when a frame is dropped.
- drop_cnt  output  8  dropped-frame count; saturates at 255.

Behaviour:
- Reset (rst=1 at an edge):
  - m_data, m_valid, m_index, m_last, m_frame, overflow and drop_cnt all go to 0.
  - Both bank-full flags clear; wr_bank=0, rd_bank=0, wr_cnt=0.
  - Write FSM goes to W_FILL; read FSM goes to R_IDLE.
  - Reset mid-frame discards all partial and buffered data.
- Storage is 2 x FRAME_LEN x DATA_W. Only cycles with in_valid=1 count; gaps in in_valid are allowed.
- Write FSM, states W_FILL and W_DROP:
  - At wr_cnt=0 with in_valid=1, the bank acquisition decision is made.
  - If full[wr_bank]=0, or the read side releases that bank in the same cycle (release bypass), the word is written and the FSM stays in W_FILL.
  - Otherwise the FSM enters W_DROP. overflow pulses in the next cycle and drop_cnt increments (saturating). The word is discarded.
  - In W_FILL, each valid word writes mem[wr_bank][wr_cnt] and wr_cnt increments.
  - On the word with wr_cnt=FRAME_LEN-1: full[wr_bank] sets, wr_bank toggles, wr_cnt returns to 0.
  - In W_DROP, valid words are discarded while wr_cnt still counts. At FRAME_LEN-1 the FSM returns to W_FILL with wr_cnt=0.
  - The drop decision is taken only at word 0; a frame is never split or partially stored.
- Read FSM, states R_IDLE and R_STREAM:
  - R_IDLE: when full[rd_bank]=1, load the output register with mem[rd_bank][0], index 0, and the current frame sequence number. m_valid rises the cycle after the load; go to R_STREAM.
  - Latency: last input word sampled at edge t -> full set at edge t -> output register loaded at edge t+1 -> m_valid high during cycle t+1.
  - R_STREAM: while m_valid & !m_ready, m_data, m_index, m_last and m_frame hold stable.
  - On a handshake with m_index < FRAME_LEN-1, load the next word the same edge (one word per cycle at m_ready=1, no bubbles).
  - On a handshake with m_last=1: clear full[rd_bank], toggle rd_bank, increment the frame sequence number.
  - If the other bank is already full at that edge, load its word 0 at the same edge (back-to-back frames with no gap). Otherwise drop m_valid and return to R_IDLE.
- m_frame counts only delivered frames; dropped frames do not consume a sequence number.
- Simultaneous events:
  - A write completing bank A in the same cycle as the read releasing bank B: both take effect.
  - Release of bank X in the same cycle as word 0 arriving for X: the word is accepted (bypass).
- m_last = (m_index == FRAME_LEN-1) & m_valid.

Test Plan:
- Reset, then 64 valid words 0x00000000..0x0000003F with m_ready=1 -> m_valid rises 1 cycle after the last input word; 64 consecutive words 0x00..0x3F, m_index 0..63, m_last only on 0x3F, m_frame=0, drop_cnt=0.
- Two back-to-back frames with m_ready=1 -> 128 contiguous outputs with no m_valid gap; m_frame=0 then 1.
- m_ready held 0 for 3 frames (A, B, C) -> C dropped: overflow pulses once, drop_cnt=1. Releasing m_ready yields A then B (m_frame 0, 1); no words from C appear.
- Random m_ready (50%) and in_valid gaps over 10 frames with sufficient throughput -> output sequence bit-exact with input; data and index stable during stalls; drop_cnt=0.
- Assert rst mid-output (m_index=20) with bank 1 full -> the next cycle shows m_valid=0, drop_cnt=0, m_frame=0; a new frame then streams from index 0 with m_frame=0.
- Force 300 dropped frames -> drop_cnt saturates at 255; overflow still pulses for every dropped frame.
